fifo_deq_packer: RTL and testbench
==================================

# fifo_deq_packer

Width up-converter sitting directly downstream of `fifo`, on its dequeue port. Accepts one `ENTRY_WIDTH` entry per cycle over a valid/ready handshake, packs up to `PACK_RATIO` consecutive entries into one wide word, and presents that word to the next stage over a second valid/ready handshake. A `flush` input forces early emission of a partially filled word, for example at the end of a fetch group or on a redirect boundary.

## Interface
- `ENTRY_WIDTH`, 4, width of one packed entry; must match the upstream `fifo`.
- `PACK_RATIO`, 4, entries per output word; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  upstream entry valid; connects to `fifo.deq_valid`.
- `in_data`  in  `ENTRY_WIDTH`  upstream entry; connects to `fifo.deq_data`.
- `in_ready`  out  1  packer accepts an entry this cycle; connects to `fifo.deq_ready`.
- `flush`  in  1  close the current partial word at the end of this cycle.
- `out_valid`  out  1  packed word available.
- `out_data`  out  `PACK_RATIO*ENTRY_WIDTH`  packed word.
  - Lane i occupies `[i*ENTRY_WIDTH +: ENTRY_WIDTH]`.
  - Lane 0 holds the oldest entry.
  - Unfilled lanes read 0.
- `out_count`  out  `$clog2(PACK_RATIO+1)`  number of valid lanes in `out_data` (1..`PACK_RATIO`) while `out_valid`; 0 otherwise.
- `out_ready`  in  1  downstream accepts the packed word.

## Operation
- State: lane registers `lane[0..PACK_RATIO-1]`, fill counter `count` (0..`PACK_RATIO`), FSM state ∈ {FILL, DRAIN}.
- Transfer events:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
- FILL:
  - Outputs: `in_ready`=1, `out_valid`=0.
  - in_fire writes `lane[count]` ← `in_data` and increments `count`.
  - Transition to DRAIN when either:
    - in_fire with `count == PACK_RATIO-1` (word full); or
    - `flush`=1 and (`count` > 0 or in_fire). A beat arriving in the flush cycle is included in the word.
  - `flush` with `count == 0` and no in_fire: ignored; stay in FILL.
- DRAIN:
  - Outputs: `out_valid`=1; `out_data` = lanes; `out_count` = `count`.
  - `in_ready` = `out_ready`; no entry is accepted unless the word leaves in the same cycle.
  - out_fire without in_fire:
    - All lanes ← 0, `count` ← 0, next state FILL.
  - out_fire with in_fire:
    - `lane[0]` ← `in_data`, other lanes ← 0, `count` ← 1, next state FILL.
    - If `flush` is also 1, next state is DRAIN with `count` = 1.
  - No out_fire: hold all state; `out_data` and `out_count` stay stable.
  - `flush` without in_fire is ignored in DRAIN.
- Arithmetic: `count` never exceeds `PACK_RATIO`; no wrap-around.
- Reset, mid-operation: any cycle with `rst`=1 discards any partial or pending word with no output pulse. The reset values below apply.
- Reset values:
  - state FILL, `count` 0, all lanes 0.
  - `out_valid` 0, `out_data` 0, `out_count` 0.
  - `in_ready` 1 from the first cycle after reset deasserts.

## Timing
- `out_valid`, `out_data` and `out_count` come from registers only; no combinational path from `in_*` or `flush` to them.
- `in_ready` is combinational from FSM state and `out_ready` only. It has no dependency on `in_valid`, so there is no loop with the `fifo`.
- Latency: the last entry of a word (or the flush cycle) at edge N → `out_valid` high in the cycle after edge N.
- Throughput: with `out_ready` held at 1, one word per `PACK_RATIO` input beats, with no lost input cycle at word boundaries.
- Once `out_valid` is asserted, it stays asserted and `out_data`/`out_count` stay stable until out_fire or `rst`.

## Test plan
- **Reset:** hold `rst` 1 for 2 cycles with `in_valid` 1 → `out_valid` 0, `out_data` 0, `out_count` 0, `in_ready` 1; no entry captured.
- **Full pack:** stream `in_data` 1,2,3,4 on consecutive cycles with `out_ready` 1 → next cycle `out_valid` 1, `out_data` 16'h4321, `out_count` 4.
- **Back-to-back:** stream 1..8 continuously with `out_ready` 1 → words 16'h4321 then 16'h8765; `in_ready` never drops.
- **Backpressure:**
  - Fill 4 entries, then hold `out_ready` 0 for 3 cycles → `out_data` stable at 16'h4321 and `in_ready` 0 throughout.
  - Raise `out_ready` while presenting 9 → word leaves, `lane[0]` = 9, `count` 1.
- **Flush partial:**
  - Send 5, 6, then `flush` with `in_valid` 0 → `out_data` 16'h0065, `out_count` 2.
  - `flush` with `count` 0 and `in_valid` 0 → no output.
- **Flush with beat:** send A, B, then C with `flush` in the same cycle → `out_data` 16'h0CBA, `out_count` 3.
- **Random vs golden:** 10000 random cycles against a golden model, paired with `fifo` → outputs match every cycle.

Source files
------------

// File: rtl/fifo_deq_packer.sv
// Width up-converter on the dequeue side of a fifo: packs up to PACK_RATIO
// entries into one wide word, with flush to close a partial word early.
module fifo_deq_packer #(
  parameter  int ENTRY_WIDTH = 4,
  parameter  int PACK_RATIO  = 4,
  localparam int DATA_WIDTH  = PACK_RATIO * ENTRY_WIDTH,
  localparam int COUNT_WIDTH = $clog2(PACK_RATIO + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ENTRY_WIDTH-1:0] in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COUNT_WIDTH-1:0] out_count,
  input  logic                   out_ready
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX  = COUNT_WIDTH'(PACK_RATIO - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [ENTRY_WIDTH-1:0] lane_q [PACK_RATIO];
  logic [ENTRY_WIDTH-1:0] lane_d [PACK_RATIO];

  logic in_fire;
  logic out_fire;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_count = out_valid ? count_q : '0;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      out_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = out_valid ? lane_q[i] : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    for (int i = 0; i < PACK_RATIO; i++) begin
      lane_d[i] = lane_q[i];
    end

    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          for (int i = 0; i < PACK_RATIO; i++) begin
            if (COUNT_WIDTH'(i) == count_q) begin
              lane_d[i] = in_data;
            end
          end
          count_d = count_q + COUNT_ONE;
        end
        // A beat arriving together with flush belongs to the word being closed.
        if ((in_fire && (count_q == LAST_IDX)) ||
            (flush && ((count_q != '0) || in_fire))) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (out_fire) begin
          for (int i = 0; i < PACK_RATIO; i++) begin
            lane_d[i] = '0;
          end
          count_d = '0;
          state_d = FILL;
          if (in_fire) begin
            lane_d[0] = in_data;
            count_d   = COUNT_ONE;
            if (flush) begin
              state_d = DRAIN;
            end
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      for (int i = 0; i < PACK_RATIO; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < PACK_RATIO; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo_deq_packer.sv
// Bench for fifo_deq_packer: directed vectors with literal expectations plus a
// queue-based model compared against the DUT on every cycle.
module tb_fifo_deq_packer;

  localparam int EW = 4;
  localparam int PR = 4;
  localparam int DW = PR * EW;
  localparam int CW = $clog2(PR + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [EW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_ready;

  int n_vectors     = 0;
  int n_miscompares = 0;

  fifo_deq_packer #(.ENTRY_WIDTH(EW), .PACK_RATIO(PR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Model: entries gathered so far, and the closed word waiting downstream.
  logic [EW-1:0] part_q[$];
  logic [EW-1:0] word_q[$];
  bit            have_word  = 1'b0;
  bit            model_init = 1'b0;

  function automatic logic [DW-1:0] model_data();
    logic [DW-1:0] d;
    d = '0;
    if (have_word) begin
      for (int i = 0; i < word_q.size(); i++) d[i*EW +: EW] = word_q[i];
    end
    return d;
  endfunction

  function automatic logic [CW-1:0] model_count();
    return have_word ? CW'(word_q.size()) : '0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge; caller checks 1 unit later.
  task automatic applyStimulus(input logic r, input logic v, input logic [EW-1:0] d,
                               input logic f, input logic ordy);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; flush = f; out_ready = ordy;
    #1;
  endtask

  always @(posedge clk) begin
    bit m_ready;
    if (rst) begin
      part_q.delete();
      word_q.delete();
      have_word  = 1'b0;
      model_init = 1'b1;
    end else if (model_init) begin
      m_ready = !have_word || out_ready;
      if (have_word && out_ready) begin
        have_word = 1'b0;
        word_q.delete();
      end
      if (in_valid && m_ready) part_q.push_back(in_data);
      if (part_q.size() == PR || (flush && part_q.size() > 0)) begin
        word_q = part_q;
        part_q.delete();
        have_word = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_init) begin
      checkOutput("out_valid", 32'(out_valid), 32'(have_word));
      checkOutput("out_data", 32'(out_data), 32'(model_data()));
      checkOutput("out_count", 32'(out_count), 32'(model_count()));
      checkOutput("in_ready", 32'(in_ready), 32'(!have_word || out_ready));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 4'h7; flush = 1'b0; out_ready = 1'b1;

    // Reset held two edges with in_valid high
    applyStimulus(1, 1, 4'h7, 0, 1);
    applyStimulus(0, 0, 4'h0, 0, 1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_out_count", 32'(out_count), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

    // Full pack and back-to-back 1..8
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 1, EW'(k), 0, 1);
      checkOutput("b2b_in_ready", 32'(in_ready), 32'h1);
      if (k == 5) begin
        checkOutput("full_valid", 32'(out_valid), 32'h1);
        checkOutput("full_data", 32'(out_data), 32'h4321);
        checkOutput("full_count", 32'(out_count), 32'h4);
        checkOutput("model_full_data", 32'(model_data()), 32'h4321);
      end
    end
    applyStimulus(0, 0, 4'h0, 0, 0);
    checkOutput("b2b_word2", 32'(out_data), 32'h8765);
    checkOutput("b2b_word2_count", 32'(out_count), 32'h4);
    checkOutput("b2b_hold_in_ready", 32'(in_ready), 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 1);
    checkOutput("b2b_word2_hold", 32'(out_data), 32'h8765);
    applyStimulus(0, 0, 4'h0, 0, 1);
    checkOutput("b2b_drained", 32'(out_valid), 32'h0);

    // Backpressure: word held for 3 cycles, then leaves while 9 enters
    for (int k = 1; k <= 4; k++) applyStimulus(0, 1, EW'(k), 0, 0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(0, 1, 4'h9, 0, 0);
      checkOutput("bp_data", 32'(out_data), 32'h4321);
      checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
      checkOutput("bp_valid", 32'(out_valid), 32'h1);
    end
    applyStimulus(0, 1, 4'h9, 0, 1);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'h1);
    applyStimulus(0, 0, 4'h0, 1, 0);
    checkOutput("bp_after_fire_valid", 32'(out_valid), 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 0);
    checkOutput("bp_lane0_data", 32'(out_data), 32'h0009);
    checkOutput("bp_lane0_count", 32'(out_count), 32'h1);
    applyStimulus(0, 0, 4'h0, 0, 1);

    // Flush partial, then flush on an empty packer
    applyStimulus(0, 1, 4'h5, 0, 1);
    applyStimulus(0, 1, 4'h6, 0, 1);
    applyStimulus(0, 0, 4'h0, 1, 1);
    applyStimulus(0, 0, 4'h0, 0, 0);
    checkOutput("flush_data", 32'(out_data), 32'h0065);
    checkOutput("flush_count", 32'(out_count), 32'h2);
    checkOutput("model_flush_count", 32'(model_count()), 32'h2);
    applyStimulus(0, 0, 4'h0, 1, 1);
    applyStimulus(0, 0, 4'h0, 1, 1);
    checkOutput("flush_drained", 32'(out_valid), 32'h0);
    applyStimulus(0, 0, 4'h0, 0, 1);
    checkOutput("flush_empty_ignored", 32'(out_valid), 32'h0);

    // Flush arriving with a beat
    applyStimulus(0, 1, 4'hA, 0, 1);
    applyStimulus(0, 1, 4'hB, 0, 1);
    applyStimulus(0, 1, 4'hC, 1, 0);
    applyStimulus(0, 0, 4'h0, 0, 0);
    checkOutput("flush_beat_data", 32'(out_data), 32'h0CBA);
    checkOutput("flush_beat_count", 32'(out_count), 32'h3);
    checkOutput("model_flush_beat_data", 32'(model_data()), 32'h0CBA);
    applyStimulus(0, 0, 4'h0, 0, 1);
    applyStimulus(0, 0, 4'h0, 0, 1);
    checkOutput("flush_beat_drained", 32'(out_valid), 32'h0);

    // Random traffic, including occasional mid-stream reset
    for (int n = 0; n < 10000; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                    EW'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) != 0));
    end
    applyStimulus(0, 0, 4'h0, 0, 1);
    applyStimulus(0, 0, 4'h0, 0, 1);
    @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
